mem_arbiter: RTL and testbench

Byte-serial memory controller arbitrating between the instruction cache and the load/store buffer for the single 8-bit RAM/IO port. Successor to the single-channel fetch controller: parametrised fetch width, a second channel with 1/2/4-byte reads and writes, round-robin arbitration, an IO-buffer write stall and speculative-read abort on flush. It sits between the ICache/LSB and the top-level RAM port.

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, its two requesters (ICache, load/store buffer)
// and the byte-wide RAM/IO port.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int IC_LINE_BYTES = 4
);
    logic [ADDR_WIDTH-1:0]      mem_a;
    logic [7:0]                 mem_write;
    logic                       is_write;
    logic                       io_buffer_full;
    logic [7:0]                 mem_result;
    logic                       flush;
    logic                       ic_req;
    logic [ADDR_WIDTH-1:0]      ic_addr;
    logic [8*IC_LINE_BYTES-1:0] ic_data;
    logic                       ic_done;
    logic                       ls_req;
    logic                       ls_we;
    logic [1:0]                 ls_size;
    logic [ADDR_WIDTH-1:0]      ls_addr;
    logic [31:0]                ls_wdata;
    logic [31:0]                ls_rdata;
    logic                       ls_done;

    modport slave (
        output mem_a, mem_write, is_write, ic_data, ic_done, ls_rdata, ls_done,
        input  io_buffer_full, mem_result, flush, ic_req, ic_addr,
               ls_req, ls_we, ls_size, ls_addr, ls_wdata
    );

    modport master (
        input  mem_a, mem_write, is_write, ic_data, ic_done, ls_rdata, ls_done,
        output io_buffer_full, mem_result, flush, ic_req, ic_addr,
               ls_req, ls_we, ls_size, ls_addr, ls_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial RAM/IO controller shared by the ICache (line fetches) and the
// load/store buffer (1/2/4-byte loads and stores), round-robin arbitrated.
module mem_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int IC_LINE_BYTES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    mem_arbiter_if.slave bus
);
    localparam int MAX_N = (IC_LINE_BYTES > 4) ? IC_LINE_BYTES : 4;
    localparam int K_W   = $clog2(MAX_N + 1);
    localparam int BUF_W = 8 * MAX_N;
    localparam int IC_W  = 8 * IC_LINE_BYTES;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    logic [1:0]            state_r;
    logic [K_W-1:0]        k_r;
    logic [K_W-1:0]        len_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic                  owner_ls_r;
    logic                  last_ls_r;   // set: the LS channel wins the next tie
    logic [31:0]           wdata_r;
    logic [BUF_W-1:0]      buf_r;
    logic [IC_W-1:0]       ic_data_r;
    logic                  ic_done_r;
    logic [31:0]           ls_rdata_r;
    logic                  ls_done_r;

    logic                  ic_pend_s;
    logic                  ls_pend_s;
    logic                  grant_ic_s;
    logic                  grant_ls_s;
    logic [K_W-1:0]        ls_len_s;
    logic                  capture_s;
    logic [K_W-1:0]        byte_idx_s;
    logic [BUF_W-1:0]      next_buf_s;
    logic [31:0]           ls_mask_s;
    logic                  io_stall_s;
    logic [ADDR_WIDTH-1:0] mem_a_s;
    logic [7:0]            mem_write_s;
    logic                  is_write_s;

    // Request qualification (flush masks reads only) and round-robin grant
    always_comb begin
        ic_pend_s  = bus.ic_req && !bus.flush;
        ls_pend_s  = bus.ls_req && (bus.ls_we || !bus.flush);
        grant_ic_s = ic_pend_s && (!ls_pend_s || !last_ls_r);
        grant_ls_s = ls_pend_s && !grant_ic_s;
        case (bus.ls_size)
            2'b00:   ls_len_s = K_W'(32'd1);
            2'b01:   ls_len_s = K_W'(32'd2);
            default: ls_len_s = K_W'(32'd4);
        endcase
    end

    // Read assembly: byte k-1 arrives while the counter shows k
    always_comb begin
        capture_s  = (state_r == ST_READ) && (k_r != '0);
        byte_idx_s = k_r - K_W'(32'd1);
        next_buf_s = buf_r;
        for (int i = 0; i < MAX_N; i++) begin
            next_buf_s[8*i +: 8] = (capture_s && (byte_idx_s == K_W'(i))) ?
                                   bus.mem_result : buf_r[8*i +: 8];
        end
        if (len_r == K_W'(32'd1)) begin
            ls_mask_s = 32'h0000_00ff;
        end else if (len_r == K_W'(32'd2)) begin
            ls_mask_s = 32'h0000_ffff;
        end else begin
            ls_mask_s = 32'hffff_ffff;
        end
    end

    // RAM port drive; the address drops to 0 after the last read byte so an IO
    // location is never read speculatively a second time
    always_comb begin
        io_stall_s  = bus.io_buffer_full && (base_r[17:16] == 2'b11);
        mem_a_s     = '0;
        mem_write_s = 8'h00;
        is_write_s  = 1'b0;
        case (state_r)
            ST_READ: begin
                if (k_r != len_r) begin
                    mem_a_s = base_r + ADDR_WIDTH'(k_r);
                end else begin
                    mem_a_s = '0;
                end
            end
            ST_WRITE: begin
                mem_a_s = base_r + ADDR_WIDTH'(k_r);
                case (k_r[1:0])
                    2'd0:    mem_write_s = wdata_r[7:0];
                    2'd1:    mem_write_s = wdata_r[15:8];
                    2'd2:    mem_write_s = wdata_r[23:16];
                    default: mem_write_s = wdata_r[31:24];
                endcase
                is_write_s = rdy && !io_stall_s;
            end
            default: begin
                mem_a_s = '0;
            end
        endcase
    end

    // Controller state, byte counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            k_r        <= '0;
            len_r      <= '0;
            base_r     <= '0;
            owner_ls_r <= 1'b0;
            last_ls_r  <= 1'b0;
            wdata_r    <= 32'h0000_0000;
            buf_r      <= '0;
            ic_data_r  <= '0;
            ic_done_r  <= 1'b0;
            ls_rdata_r <= 32'h0000_0000;
            ls_done_r  <= 1'b0;
        end else if (rdy) begin
            ic_done_r <= 1'b0;
            ls_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    k_r <= '0;
                    // a request still high during its done cycle is stale
                    if (!ic_done_r && !ls_done_r && grant_ic_s) begin
                        state_r    <= ST_READ;
                        owner_ls_r <= 1'b0;
                        base_r     <= bus.ic_addr;
                        len_r      <= K_W'(IC_LINE_BYTES);
                        last_ls_r  <= 1'b1;
                    end else if (!ic_done_r && !ls_done_r && grant_ls_s) begin
                        state_r    <= bus.ls_we ? ST_WRITE : ST_READ;
                        owner_ls_r <= 1'b1;
                        base_r     <= bus.ls_addr;
                        len_r      <= ls_len_s;
                        wdata_r    <= bus.ls_wdata;
                        last_ls_r  <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (bus.flush) begin
                        state_r <= ST_IDLE;
                        k_r     <= '0;
                    end else if (k_r == len_r) begin
                        state_r <= ST_IDLE;
                        k_r     <= '0;
                        if (owner_ls_r) begin
                            ls_rdata_r <= next_buf_s[31:0] & ls_mask_s;
                            ls_done_r  <= 1'b1;
                        end else begin
                            ic_data_r <= next_buf_s[IC_W-1:0];
                            ic_done_r <= 1'b1;
                        end
                    end else begin
                        k_r   <= k_r + K_W'(32'd1);
                        buf_r <= next_buf_s;
                    end
                end
                ST_WRITE: begin
                    if (io_stall_s) begin
                        k_r <= k_r;
                    end else if (k_r == len_r - K_W'(32'd1)) begin
                        state_r   <= ST_IDLE;
                        k_r       <= '0;
                        ls_done_r <= 1'b1;
                    end else begin
                        k_r <= k_r + K_W'(32'd1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    k_r     <= '0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign bus.mem_a     = mem_a_s;
    assign bus.mem_write = mem_write_s;
    assign bus.is_write  = is_write_s;
    assign bus.ic_data   = ic_data_r;
    assign bus.ic_done   = ic_done_r;
    assign bus.ls_rdata  = ls_rdata_r;
    assign bus.ls_done   = ls_done_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte-wide RAM model with write log, linear
// stimulus sequence, expected values written out by hand.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LB = 4;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .IC_LINE_BYTES(LB)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .IC_LINE_BYTES(LB)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]    ram [0:65535];
    int            wr_cnt = 0;
    logic [7:0]    wr_data [0:63];
    logic [AW-1:0] wr_addr [0:63];
    int            checks = 0;
    int            errors = 0;
    int            w0;
    logic [7:0]    exp_b [4];

    // RAM: read data one cycle after its address, frozen with the rest of the system
    always @(posedge clk) begin
        if (rdy) begin
            bus.mem_result <= ram[bus.mem_a[15:0]];
            if (bus.is_write) begin
                wr_data[wr_cnt[5:0]] <= bus.mem_write;
                wr_addr[wr_cnt[5:0]] <= bus.mem_a;
                wr_cnt               <= wr_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_a"},    64'(bus.mem_a),     64'h0);
        chk({tag, "_mem_wr"},   64'(bus.mem_write), 64'h0);
        chk({tag, "_is_write"}, 64'(bus.is_write),  64'h0);
        chk({tag, "_ic_data"},  64'(bus.ic_data),   64'h0);
        chk({tag, "_ic_done"},  64'(bus.ic_done),   64'h0);
        chk({tag, "_ls_rdata"}, 64'(bus.ls_rdata),  64'h0);
        chk({tag, "_ls_done"},  64'(bus.ls_done),   64'h0);
    endtask

    initial begin
        ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
        ram[16'h1004] = 8'hAA; ram[16'h1005] = 8'hBB; ram[16'h1006] = 8'hCC; ram[16'h1007] = 8'hDD;
        ram[16'h2000] = 8'h11; ram[16'h2001] = 8'h22; ram[16'h2002] = 8'hEF; ram[16'h2003] = 8'hBE;
        ram[16'h2004] = 8'h78; ram[16'h2005] = 8'h56; ram[16'h2006] = 8'h34; ram[16'h2007] = 8'h12;
        rst = 1'b1; rdy = 1'b1;
        bus.io_buffer_full = 1'b0; bus.flush = 1'b0;
        bus.ic_req = 1'b0; bus.ic_addr = 32'h0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = 2'b00;
        bus.ls_addr = 32'h0; bus.ls_wdata = 32'h0;

        tick(2);
        chk_all_zero("reset");
        rst = 1'b0;

        // IC line fetch from 0x1000
        bus.ic_addr = 32'h1000; bus.ic_req = 1'b1;
        chk("ic_idle_a", 64'(bus.mem_a), 64'h0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("ic_fetch_a", 64'(bus.mem_a), 64'(32'h1000 + 32'(k)));
            chk("ic_fetch_nodone", 64'(bus.ic_done), 64'h0);
        end
        tick(1);
        chk("ic_tail_a0", 64'(bus.mem_a), 64'h0);
        chk("ic_tail_nodone", 64'(bus.ic_done), 64'h0);
        tick(1);
        chk("ic_done", 64'(bus.ic_done), 64'h1);
        chk("ic_data", 64'(bus.ic_data), 64'h0000_0513);
        tick(1);
        chk("ic_stale_req_ignored", 64'(bus.mem_a), 64'h0);
        chk("ic_done_pulse", 64'(bus.ic_done), 64'h0);
        bus.ic_req = 1'b0;
        tick(1);
        chk("ic_idle_after", 64'(bus.mem_a), 64'h0);

        // LS half load then byte load from 0x2002
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'b01; bus.ls_addr = 32'h2002;
        tick(1); chk("half_a0", 64'(bus.mem_a), 64'h2002);
        tick(1); chk("half_a1", 64'(bus.mem_a), 64'h2003);
        tick(1); chk("half_tail_a", 64'(bus.mem_a), 64'h0);
        chk("half_nodone", 64'(bus.ls_done), 64'h0);
        tick(1);
        chk("half_done", 64'(bus.ls_done), 64'h1);
        chk("half_rdata", 64'(bus.ls_rdata), 64'h0000_BEEF);
        tick(1);
        bus.ls_size = 2'b00;
        tick(1); chk("byte_a0", 64'(bus.mem_a), 64'h2002);
        tick(1); chk("byte_tail_a", 64'(bus.mem_a), 64'h0);
        tick(1);
        chk("byte_done", 64'(bus.ls_done), 64'h1);
        chk("byte_rdata", 64'(bus.ls_rdata), 64'h0000_00EF);
        tick(1);
        bus.ls_req = 1'b0;
        tick(1);

        // Byte store to IO address with the output buffer full for 3 cycles
        w0 = wr_cnt;
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'b00;
        bus.ls_addr = 32'h0003_0000; bus.ls_wdata = 32'h0000_0041;
        bus.io_buffer_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick(1);
            chk("io_stall_nowrite", 64'(bus.is_write), 64'h0);
            chk("io_stall_a", 64'(bus.mem_a), 64'h0003_0000);
        end
        tick(1);
        bus.io_buffer_full = 1'b0;
        #1;
        chk("io_write", 64'(bus.is_write), 64'h1);
        chk("io_write_data", 64'(bus.mem_write), 64'h41);
        chk("io_write_nodone", 64'(bus.ls_done), 64'h0);
        tick(1);
        chk("io_done", 64'(bus.ls_done), 64'h1);
        chk("io_after_nowrite", 64'(bus.is_write), 64'h0);
        tick(1);
        bus.ls_req = 1'b0;
        chk("io_write_count", 64'(wr_cnt - w0), 64'd1);
        chk("io_write_addr", 64'(wr_addr[w0]), 64'h0003_0000);

        // Word store with flush raised mid-transfer: all bytes still go out
        tick(1);
        w0 = wr_cnt;
        exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'b10;
        bus.ls_addr = 32'h4000; bus.ls_wdata = 32'hDDCC_BBAA;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("wstore_a", 64'(bus.mem_a), 64'(32'h4000 + 32'(k)));
            chk("wstore_we", 64'(bus.is_write), 64'h1);
            chk("wstore_data", 64'(bus.mem_write), 64'(exp_b[k]));
            if (k == 0) bus.flush = 1'b1;
            if (k == 2) bus.flush = 1'b0;
        end
        tick(1);
        chk("wstore_done", 64'(bus.ls_done), 64'h1);
        tick(1);
        bus.ls_req = 1'b0;
        chk("wstore_count", 64'(wr_cnt - w0), 64'd4);

        // IC fetch aborted by flush at k=2
        bus.ic_addr = 32'h1004; bus.ic_req = 1'b1;
        tick(1); chk("abort_a0", 64'(bus.mem_a), 64'h1004);
        tick(2); chk("abort_a2", 64'(bus.mem_a), 64'h1006);
        bus.flush = 1'b1; bus.ic_req = 1'b0;
        tick(1);
        bus.flush = 1'b0;
        chk("abort_idle_a", 64'(bus.mem_a), 64'h0);
        chk("abort_nodone", 64'(bus.ic_done), 64'h0);
        chk("abort_data_kept", 64'(bus.ic_data), 64'h0000_0513);
        tick(1);
        chk("abort_nodone2", 64'(bus.ic_done), 64'h0);

        // Reset, then both channels request together: IC first, then alternate
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        bus.ic_addr = 32'h1000; bus.ic_req = 1'b1;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'b10; bus.ls_addr = 32'h2000;
        tick(1); chk("tie1_ic_first", 64'(bus.mem_a), 64'h1000);
        tick(5);
        chk("tie1_ic_done", 64'(bus.ic_done), 64'h1);
        chk("tie1_ls_nodone", 64'(bus.ls_done), 64'h0);
        tick(1);
        bus.ic_req = 1'b0;
        tick(1); chk("tie1_ls_next", 64'(bus.mem_a), 64'h2000);
        tick(5);
        chk("tie1_ls_done", 64'(bus.ls_done), 64'h1);
        chk("tie1_ls_rdata", 64'(bus.ls_rdata), 64'hBEEF_2211);
        tick(1);
        bus.ic_req = 1'b1;
        tick(1); chk("tie2_ic", 64'(bus.mem_a), 64'h1000);
        tick(5);
        chk("tie2_ic_done", 64'(bus.ic_done), 64'h1);
        tick(2); chk("tie3_ls", 64'(bus.mem_a), 64'h2000);
        tick(5);
        chk("tie3_ls_done", 64'(bus.ls_done), 64'h1);
        bus.ic_req = 1'b0; bus.ls_req = 1'b0;
        tick(1); chk("tie_idle", 64'(bus.mem_a), 64'h0);

        // Word load with rdy low for 2 cycles mid-transfer
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'b10; bus.ls_addr = 32'h2004;
        tick(1); chk("rdy_a0", 64'(bus.mem_a), 64'h2004);
        tick(1); chk("rdy_a1", 64'(bus.mem_a), 64'h2005);
        rdy = 1'b0;
        tick(1); chk("rdy_frozen_a", 64'(bus.mem_a), 64'h2005);
        tick(1);
        rdy = 1'b1;
        chk("rdy_resume_a", 64'(bus.mem_a), 64'h2005);
        tick(1); chk("rdy_a2", 64'(bus.mem_a), 64'h2006);
        tick(1); chk("rdy_a3", 64'(bus.mem_a), 64'h2007);
        chk("rdy_no_early_done", 64'(bus.ls_done), 64'h0);
        tick(1); chk("rdy_tail_a", 64'(bus.mem_a), 64'h0);
        tick(1);
        chk("rdy_done", 64'(bus.ls_done), 64'h1);
        chk("rdy_rdata", 64'(bus.ls_rdata), 64'h1234_5678);
        tick(1);
        bus.ls_req = 1'b0;
        tick(1);

        // Word store: rdy low blocks the write strobe, then reset mid-transfer
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'b10;
        bus.ls_addr = 32'h4010; bus.ls_wdata = 32'h4433_2211;
        tick(1);
        chk("rstw_we0", 64'(bus.is_write), 64'h1);
        chk("rstw_a0", 64'(bus.mem_a), 64'h4010);
        tick(1);
        rdy = 1'b0;
        #1;
        chk("rstw_rdy_low_nowrite", 64'(bus.is_write), 64'h0);
        chk("rstw_rdy_low_a", 64'(bus.mem_a), 64'h4011);
        tick(1);
        rdy = 1'b1;
        #1;
        chk("rstw_reissue_we", 64'(bus.is_write), 64'h1);
        chk("rstw_reissue_a", 64'(bus.mem_a), 64'h4011);
        chk("rstw_reissue_data", 64'(bus.mem_write), 64'h22);
        rst = 1'b1; bus.ls_req = 1'b0;
        tick(1);
        chk_all_zero("rst_mid_write");
        rst = 1'b0;
        tick(1);
        chk("post_rst_idle_a", 64'(bus.mem_a), 64'h0);
        chk("post_rst_idle_we", 64'(bus.is_write), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
